// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-Stream slave receive stage.
package axis_pkg;

   // Reference layout of one FIFO entry at the default 32-bit data width.
   // The top declares a local copy whose data field follows WIDTH.
   localparam int unsigned ENTRY_DATA_W = 32;

   typedef struct packed {
      logic                    last;
      logic [ENTRY_DATA_W-1:0] data;
   } axis_entry_t;

   // Expected-length checker states
   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } len_state_t;

   // A packet's first beat counts as 1, so the counter restarts at 1
   localparam int unsigned CNT_RST = 1;

endpackage

// File: rtl/axis_s_fifo.sv
// First-word-fall-through FIFO. Pointers carry one extra MSB so that full and
// empty can be told apart when the index bits are equal.
module axis_s_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Storage is data only and is not reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Pointer update; push and pop are already qualified by the caller
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/axis_s_pkt.sv
// AXI-Stream slave receive stage: FWFT buffering, per-packet beat count and an
// optional expected-length check enabled by the macro AXIS_S_PKT_LEN_CHECK_EN.
module axis_s_pkt
   import axis_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LEN_WIDTH = 10,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   output logic [WIDTH-1:0]     data_out,
   output logic                 last_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic                 len_valid,
   output logic [LEN_WIDTH-1:0] len_out,
   output logic                 len_ovf,
   input  logic                 config_valid,
   input  logic [LEN_WIDTH-1:0] config_len,
   output logic                 len_err
);

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] data;
   } entry_t;

   entry_t               wr_entry;
   entry_t               rd_entry;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic [LEN_WIDTH-1:0] beat_cnt;
   logic                 ovf;

   // No write-through: a full FIFO refuses beats even while it is being popped
   assign s_axis_tready = !full && !rst;
   assign push          = s_axis_tvalid && s_axis_tready;
   assign valid_out     = !empty;
   assign pop           = valid_out && ready_in;

   assign wr_entry.last = s_axis_tlast;
   assign wr_entry.data = s_axis_tdata;
   assign data_out      = rd_entry.data;
   assign last_out      = rd_entry.last;

   axis_s_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .dout  (rd_entry),
      .full  (full),
      .empty (empty)
   );

   // Beat counter: saturates with a sticky overflow, reports and restarts on tlast
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt  <= LEN_WIDTH'(CNT_RST);
         ovf       <= 1'b0;
         len_valid <= 1'b0;
         len_out   <= '0;
         len_ovf   <= 1'b0;
      end else begin
         len_valid <= 1'b0;
         if (push) begin
            if (s_axis_tlast) begin
               len_out   <= beat_cnt;
               len_ovf   <= ovf;
               len_valid <= 1'b1;
               beat_cnt  <= LEN_WIDTH'(CNT_RST);
               ovf       <= 1'b0;
            end else if (beat_cnt == '1) begin
               ovf <= 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

`ifdef AXIS_S_PKT_LEN_CHECK_EN
   len_state_t           state_q;
   len_state_t           state_d;
   logic [LEN_WIDTH-1:0] len_exp;
   logic                 exp_load;
   logic                 len_err_d;

   // Checker state and registered error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_err <= 1'b0;
      end else begin
         state_q <= state_d;
         len_err <= len_err_d;
      end
   end

   // Expected length is held while armed
   always_ff @(posedge clk) begin
      if (exp_load) len_exp <= config_len;
   end

   // Arm on config while idle; judge the packet that ends while armed
   always_comb begin
      state_d   = state_q;
      exp_load  = 1'b0;
      len_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (config_valid) begin
               exp_load = 1'b1;
               state_d  = ARMED;
            end
         end
         ARMED: begin
            if (push && s_axis_tlast) begin
               len_err_d = (beat_cnt != len_exp) || ovf;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{config_valid, config_len};
   assign len_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_s_pkt.sv
// Directed self-checking bench for axis_s_pkt (default build and, when
// AXIS_S_PKT_LEN_CHECK_EN is defined, the expected-length checker).
module tb_axis_s_pkt;

   logic        clk;
   logic        rst;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [31:0] data_out;
   logic        last_out;
   logic        valid_out;
   logic        ready_in;
   logic        len_valid;
   logic [9:0]  len_out;
   logic        len_ovf;
   logic        config_valid;
   logic [9:0]  config_len;
   logic        len_err;

   // Second instance with a 3-bit counter for saturation
   logic [31:0] s2_tdata;
   logic        s2_tvalid;
   logic        s2_tready;
   logic        s2_tlast;
   logic [31:0] d2_out;
   logic        l2_out;
   logic        v2_out;
   logic        r2_in;
   logic        lv2;
   logic [2:0]  lo2;
   logic        lovf2;
   logic        cv2;
   logic [2:0]  cl2;
   logic        le2;

   int checks = 0;
   int errors = 0;

   axis_s_pkt #(.WIDTH(32), .LEN_WIDTH(10), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .data_out(data_out), .last_out(last_out), .valid_out(valid_out),
      .ready_in(ready_in), .len_valid(len_valid), .len_out(len_out),
      .len_ovf(len_ovf), .config_valid(config_valid), .config_len(config_len),
      .len_err(len_err)
   );

   axis_s_pkt #(.WIDTH(32), .LEN_WIDTH(3), .DEPTH(4)) dut_s (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid),
      .s_axis_tready(s2_tready), .s_axis_tlast(s2_tlast),
      .data_out(d2_out), .last_out(l2_out), .valid_out(v2_out),
      .ready_in(r2_in), .len_valid(lv2), .len_out(lo2),
      .len_ovf(lovf2), .config_valid(cv2), .config_len(cl2),
      .len_err(le2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic l);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
   endtask

   task automatic idle_in;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out: got %0b want 0", valid_out); end
      checks++; if (len_valid !== 1'b0) begin errors++; $display("FAIL rst_len_valid: got %0b want 0", len_valid); end
      checks++; if (len_out !== 10'd0) begin errors++; $display("FAIL rst_len_out: got %0d want 0", len_out); end
      checks++; if (len_ovf !== 1'b0) begin errors++; $display("FAIL rst_len_ovf: got %0b want 0", len_ovf); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err: got %0b want 0", len_err); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b want 0", s_axis_tready); end
      rst = 1'b0;
      tick;
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_rst_tready: got %0b want 1", s_axis_tready); end
   endtask

   task automatic test_basic;
      ready_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         beat(32'hA0 + i, i == 3);
         tick;
         checks++; if (valid_out !== 1'b1 || data_out !== 32'hA0 + i) begin errors++; $display("FAIL basic_data%0d: got v=%0b d=%h want v=1 d=%h", i, valid_out, data_out, 32'hA0 + i); end
         checks++; if (last_out !== (i == 3)) begin errors++; $display("FAIL basic_last%0d: got %0b want %0b", i, last_out, i == 3); end
         checks++; if (len_valid !== (i == 3)) begin errors++; $display("FAIL basic_len_valid%0d: got %0b want %0b", i, len_valid, i == 3); end
      end
      checks++; if (len_out !== 10'd4 || len_ovf !== 1'b0) begin errors++; $display("FAIL basic_len: got %0d ovf=%0b want 4 ovf=0", len_out, len_ovf); end
      idle_in;
      tick;
      checks++; if (valid_out !== 1'b0 || len_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got v=%0b lv=%0b want 0 0", valid_out, len_valid); end
   endtask

   task automatic test_full;
      ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         beat(32'hB0 + i, 1'b0);
         checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL full_tready_fill%0d: got %0b want 1", i, s_axis_tready); end
         tick;
      end
      beat(32'hB4, 1'b0);
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready_low: got %0b want 0", s_axis_tready); end
      checks++; if (valid_out !== 1'b1 || data_out !== 32'hB0) begin errors++; $display("FAIL full_head: got v=%0b d=%h want v=1 d=b0", valid_out, data_out); end
      tick;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready_hold: got %0b want 0", s_axis_tready); end
      ready_in = 1'b1;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_no_writethrough: got %0b want 0", s_axis_tready); end
      tick;
      checks++; if (s_axis_tready !== 1'b1 || data_out !== 32'hB1) begin errors++; $display("FAIL full_first_pop: got rdy=%0b d=%h want 1 b1", s_axis_tready, data_out); end
      tick;
      checks++; if (data_out !== 32'hB2) begin errors++; $display("FAIL full_d2: got %h want b2", data_out); end
      beat(32'hB5, 1'b1);
      tick;
      checks++; if (data_out !== 32'hB3) begin errors++; $display("FAIL full_d3: got %h want b3", data_out); end
      checks++; if (len_valid !== 1'b1 || len_out !== 10'd6) begin errors++; $display("FAIL full_len: got lv=%0b len=%0d want 1 6", len_valid, len_out); end
      idle_in;
      tick;
      checks++; if (data_out !== 32'hB4 || last_out !== 1'b0) begin errors++; $display("FAIL full_d4: got %h l=%0b want b4 0", data_out, last_out); end
      tick;
      checks++; if (data_out !== 32'hB5 || last_out !== 1'b1 || valid_out !== 1'b1) begin errors++; $display("FAIL full_d5: got %h l=%0b v=%0b want b5 1 1", data_out, last_out, valid_out); end
      tick;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL full_empty: got %0b want 0", valid_out); end
   endtask

   task automatic test_back_to_back;
      ready_in = 1'b1;
      beat(32'hC0, 1'b1);
      tick;
      checks++; if (len_valid !== 1'b1 || len_out !== 10'd1) begin errors++; $display("FAIL b2b_len1: got lv=%0b len=%0d want 1 1", len_valid, len_out); end
      beat(32'hC1, 1'b0);
      tick;
      checks++; if (len_valid !== 1'b0 || data_out !== 32'hC1) begin errors++; $display("FAIL b2b_gap: got lv=%0b d=%h want 0 c1", len_valid, data_out); end
      beat(32'hC2, 1'b0);
      tick;
      beat(32'hC3, 1'b1);
      tick;
      checks++; if (len_valid !== 1'b1 || len_out !== 10'd3) begin errors++; $display("FAIL b2b_len3: got lv=%0b len=%0d want 1 3", len_valid, len_out); end
      idle_in;
      tick;
   endtask

   task automatic test_saturation;
      r2_in = 1'b1;
      for (int i = 0; i < 9; i++) begin
         s2_tvalid = 1'b1; s2_tdata = 32'hD0 + i; s2_tlast = (i == 8);
         tick;
      end
      checks++; if (lv2 !== 1'b1 || lo2 !== 3'd7 || lovf2 !== 1'b1) begin errors++; $display("FAIL sat9: got lv=%0b len=%0d ovf=%0b want 1 7 1", lv2, lo2, lovf2); end
      for (int i = 0; i < 7; i++) begin
         s2_tvalid = 1'b1; s2_tdata = 32'hE0 + i; s2_tlast = (i == 6);
         tick;
      end
      checks++; if (lv2 !== 1'b1 || lo2 !== 3'd7 || lovf2 !== 1'b0) begin errors++; $display("FAIL sat7: got lv=%0b len=%0d ovf=%0b want 1 7 0", lv2, lo2, lovf2); end
      s2_tvalid = 1'b0; s2_tlast = 1'b0;
      tick;
   endtask

   task automatic send_pkt(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         beat(base + i, i == n - 1);
         tick;
      end
      idle_in;
   endtask

   task automatic test_len_check;
      ready_in = 1'b1;
`ifdef AXIS_S_PKT_LEN_CHECK_EN
      config_valid = 1'b1; config_len = 10'd5;
      tick;
      config_valid = 1'b0;
      send_pkt(5, 32'h50);
      checks++; if (len_valid !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL chk_match: got lv=%0b err=%0b want 1 0", len_valid, len_err); end
      tick;
      config_valid = 1'b1; config_len = 10'd5;
      tick;
      config_valid = 1'b0;
      send_pkt(4, 32'h60);
      checks++; if (len_valid !== 1'b1 || len_err !== 1'b1) begin errors++; $display("FAIL chk_mismatch: got lv=%0b err=%0b want 1 1", len_valid, len_err); end
      tick;
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL chk_pulse: got %0b want 0", len_err); end
      send_pkt(2, 32'h70);
      checks++; if (len_valid !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL chk_unarmed: got lv=%0b err=%0b want 1 0", len_valid, len_err); end
      tick;
      // config coincident with an idle-state tlast arms for the next packet
      beat(32'h80, 1'b0);
      tick;
      beat(32'h81, 1'b1);
      config_valid = 1'b1; config_len = 10'd2;
      tick;
      config_valid = 1'b0;
      idle_in;
      checks++; if (len_valid !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL chk_same_cycle: got lv=%0b err=%0b want 1 0", len_valid, len_err); end
      tick;
      send_pkt(3, 32'h90);
      checks++; if (len_valid !== 1'b1 || len_err !== 1'b1) begin errors++; $display("FAIL chk_next_pkt: got lv=%0b err=%0b want 1 1", len_valid, len_err); end
      tick;
`else
      config_valid = 1'b1; config_len = 10'd5;
      tick;
      config_valid = 1'b0;
      send_pkt(4, 32'h60);
      checks++; if (len_valid !== 1'b1 || len_err !== 1'b0) begin errors++; $display("FAIL chk_disabled: got lv=%0b err=%0b want 1 0", len_valid, len_err); end
      tick;
`endif
   endtask

   task automatic test_rst_mid;
      ready_in = 1'b0;
      beat(32'hF0, 1'b0);
      tick;
      beat(32'hF1, 1'b0);
      tick;
      idle_in;
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rstmid_held: got %0b want 1", valid_out); end
      rst = 1'b1;
      tick;
      checks++; if (valid_out !== 1'b0 || s_axis_tready !== 1'b0) begin errors++; $display("FAIL rstmid_flush: got v=%0b rdy=%0b want 0 0", valid_out, s_axis_tready); end
      rst = 1'b0;
      ready_in = 1'b1;
      send_pkt(3, 32'hF8);
      checks++; if (len_valid !== 1'b1 || len_out !== 10'd3) begin errors++; $display("FAIL rstmid_len: got lv=%0b len=%0d want 1 3", len_valid, len_out); end
      tick;
   endtask

   initial begin
      rst = 1'b1;
      ready_in = 1'b0;
      config_valid = 1'b0;
      config_len = '0;
      idle_in;
      s2_tdata = '0; s2_tvalid = 1'b0; s2_tlast = 1'b0;
      r2_in = 1'b0; cv2 = 1'b0; cl2 = '0;
      test_reset;
      test_basic;
      test_full;
      test_back_to_back;
      test_saturation;
      test_len_check;
      test_rst_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_s_pkt.md
# axis_s_pkt

AXI-Stream slave receive stage. It sits directly downstream of the stream master and consumes its `m_axis_*` outputs. It buffers beats in a small first-word-fall-through FIFO and hands them to a local consumer over a valid/ready interface. It also measures each packet's beat count at the `tlast` boundary and reports it, with an optional check against a configured expected length.

## Interface
- `WIDTH`, 32: data width in bits.
- `LEN_WIDTH`, 10: width of the beat counter and all length fields.
- `DEPTH`, 4: FIFO entries; must be a power of 2 and at least 2.

- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `s_axis_tdata` input WIDTH: stream data.
- `s_axis_tvalid` input 1: stream valid.
- `s_axis_tready` output 1: stream ready.
- `s_axis_tlast` input 1: last beat of the packet.
- `data_out` output WIDTH: FIFO head data.
- `last_out` output 1: tlast flag of the FIFO head.
- `valid_out` output 1: FIFO head is valid.
- `ready_in` input 1: consumer accepts the head.
- `len_valid` output 1: one-cycle pulse; a packet has completed at the input.
- `len_out` output LEN_WIDTH: beat count of the completed packet.
- `len_ovf` output 1: qualified by `len_valid`; the beat count saturated.
- `config_valid` input 1: expected-length load strobe. Used only with `AXIS_S_PKT_LEN_CHECK_EN`.
- `config_len` input LEN_WIDTH: expected beat count.
- `len_err` output 1: one-cycle pulse, coincident with `len_valid`; the checked length mismatched.

## Operation
- **Accept:** a beat is accepted when `s_axis_tvalid && s_axis_tready`.
  - `s_axis_tready = !full && !rst`, so it is 0 during reset.
  - `{tlast, tdata}` is pushed into the FIFO.
- **Drain:** `valid_out = !empty`; `data_out`/`last_out` present the head.
  - The FIFO pops when `valid_out && ready_in`.
  - `ready_in` with empty is a no-op.
- **Full FIFO:** there is no write-through. When full, `s_axis_tready` is 0 even if a pop occurs in the same cycle.
- **Simultaneous push and pop** when not full or empty: the occupancy is unchanged.
- **Beat counter `beat_cnt`:** reset value 1.
  - Each accepted beat with tlast = 0 increments it. It saturates at all-ones and sets an internal `ovf` flag; it never wraps.
  - An accepted beat with tlast = 1 registers `len_out <= beat_cnt` and `len_ovf <= ovf`, and pulses `len_valid`. It then sets `beat_cnt <= 1` and clears `ovf`.
  - A single-beat packet reports `len_out` = 1.
- **Reset values:** `valid_out` 0, `len_valid` 0, `len_out` 0, `len_ovf` 0, `len_err` 0, `s_axis_tready` 0. The FIFO is empty and the pointers are 0.
- **Reset mid-packet:** the FIFO contents and the partial count are discarded. After reset the next beat starts a new packet with count 1.

## Timing
- Input-to-output latency is 1 cycle: a beat accepted at edge N appears on `valid_out`/`data_out` in cycle N+1.
- `s_axis_tready` drops in the cycle after the push that fills the FIFO. It rises in the cycle after a pop from full.
- `len_valid`, `len_out`, `len_ovf` and `len_err` are registered. They assert in the cycle after the tlast beat is accepted.
- Full throughput: one beat per cycle when `ready_in` is held high.

## Configuration
- Macro: `AXIS_S_PKT_LEN_CHECK_EN`.
- **Defined:** a two-state FSM, IDLE and ARMED, reset to IDLE.
  - IDLE with `config_valid`: latch `config_len` into `len_exp` and go to ARMED.
  - ARMED with an accepted tlast beat: `len_err` pulses if `beat_cnt != len_exp` or `ovf` is set. Return to IDLE.
  - `config_valid` in ARMED is ignored.
  - A packet ending while in IDLE is unchecked. This includes `config_valid` in the same cycle as that tlast; the config then applies to the next packet.
- **Undefined:** the FSM is absent, `len_err` is tied to 0, and `config_valid`/`config_len` are unused.

## Structure
- Package `axis_pkg` holds:
  - a typedef for the FIFO entry, `{last, data}`;
  - the FSM state enum IDLE/ARMED;
  - the counter reset constant (1).
- One sub-module, `axis_s_fifo`: a parameterised first-word-fall-through FIFO.
  - Pointers are log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
  - It exports `full`, `empty`, head data, `push` and `pop`.
- The top level holds the accept/drain logic, the counter and the optional FSM.

## Test plan
- 4-beat packet 0xA0..0xA3, tlast on beat 4, `ready_in` = 1 → output in order at 1-cycle latency, `last_out` with 0xA3; `len_valid` pulse with `len_out` = 4.
- `ready_in` = 0, stream 6 beats → 4 accepted and `s_axis_tready` = 0 after the 4th. Raise `ready_in` → tready returns the cycle after the first pop; all 6 beats are delivered in order.
- Back-to-back packets of 1 and 3 beats → `len_out` = 1 then 3; `beat_cnt` restarts without a gap cycle.
- LEN_WIDTH = 3, 9-beat packet → `len_out` = 7 and `len_ovf` = 1.
- With the macro: `config_len` = 5 then a 5-beat packet gives `len_err` = 0. `config_len` = 5 then a 4-beat packet gives a `len_err` pulse. A packet with no config gives `len_err` = 0.
- Assert `rst` after 2 beats of a packet while the FIFO holds data → `valid_out` = 0 next cycle. A following 3-beat packet reports `len_out` = 3.
